// File: rtl/kbd_pkg.sv
// Shared keypad definitions: key code limits, entry FSM states and the
// default entry limits used by digit_entry_ctrl.
package kbd_pkg;

  // Largest key code that counts as a decimal digit.
  localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;

  // Default confirm limit and idle timeout (10 s at 50 MHz).
  localparam int DEF_MAX_VALUE   = 20;
  localparam int DEF_TIMEOUT_CYC = 500000000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_HOLD  = 2'd2
  } entry_state_e;

endpackage

// File: rtl/entry_idle_timer.sv
// Clearable idle up-counter with an expire pulse.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clr_i       - return the count to 0 (wins over inc_i)
//   inc_i       - count one idle cycle
//   expire_o    - combinational: this increment is the TIMEOUT_CYC-th idle cycle
module entry_idle_timer #(
  parameter int TIMEOUT_CYC = 500000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  assign expire_o = inc_i & ~clr_i & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || expire_o) cnt_d = '0;
    else if (inc_i)        cnt_d = cnt_q + TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/digit_entry_ctrl.sv
// Keypad digit entry controller: assembles a decimal amount from digit
// strobes, validates it on confirm and offers it downstream via valid/ready.
// Enforces a digit limit and an inactivity timeout while in ENTRY.
// Optional macro DIGIT_ENTRY_AUTOCONFIRM_EN: a full entry confirms itself
// on the cycle after the last digit (clear/start still take priority).
// Ports:
//   clk, rst_n                      - clock, asynchronous active-low reset
//   key_value, press_num            - digit key code and its strobe
//   start, clear, confirm           - control strobes
//   entry_active, entry_value,      - live entry status for the display
//   digit_cnt
//   amount, amount_valid,           - confirmed amount handshake
//   amount_ready
//   err, timeout                    - one-cycle event pulses
module digit_entry_ctrl
  import kbd_pkg::*;
#(
  parameter int MAX_DIGITS  = 2,
  parameter int MAX_VALUE   = DEF_MAX_VALUE,
  parameter int VAL_W       = 7,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       key_value,
  input  logic             press_num,
  input  logic             start,
  input  logic             clear,
  input  logic             confirm,
  output logic             entry_active,
  output logic [VAL_W-1:0] entry_value,
  output logic [1:0]       digit_cnt,
  output logic [VAL_W-1:0] amount,
  output logic             amount_valid,
  input  logic             amount_ready,
  output logic             err,
  output logic             timeout
);

  localparam int            XW  = VAL_W + 4;
  localparam logic [XW-1:0] TEN = XW'(10);

  entry_state_e     state_q, state_d;
  logic [VAL_W-1:0] value_q, value_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [VAL_W-1:0] amount_q, amount_d;
  logic             av_q, av_d;
  logic             err_q, err_d;
  logic             to_q, to_d;
  logic             act_q, act_d;
  logic [VAL_W-1:0] ev_q, ev_d;

  logic             tmr_clr, tmr_inc, tmr_expire;
  logic             full, do_confirm, digit_ok;
  logic [XW-1:0]    mac;

  entry_idle_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (tmr_clr),
    .inc_i    (tmr_inc),
    .expire_o (tmr_expire)
  );

  assign full = (int'(cnt_q) >= MAX_DIGITS);

`ifdef DIGIT_ENTRY_AUTOCONFIRM_EN
  assign do_confirm = confirm | full;
`else
  assign do_confirm = confirm;
`endif

  assign digit_ok = press_num && (key_value <= KEY_DIGIT_MAX) && !full;
  // Digit limit bounds the result, so truncating back to VAL_W is safe.
  assign mac      = {4'b0, value_q} * TEN + XW'(key_value);

  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    cnt_d    = cnt_q;
    amount_d = amount_q;
    av_d     = av_q;
    err_d    = 1'b0;
    to_d     = 1'b0;
    tmr_clr  = 1'b1;
    tmr_inc  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ENTRY;
          value_d = '0;
          cnt_d   = '0;
        end
      end

      ST_ENTRY: begin
        tmr_clr = 1'b0;
        if (clear || start) begin
          value_d = '0;
          cnt_d   = '0;
          tmr_clr = 1'b1;
        end else if (do_confirm) begin
          tmr_clr = 1'b1;
          if (cnt_q == 2'd0) begin
            // Empty entry: nothing to submit, only counts as activity.
          end else if (value_q == '0 || int'(value_q) > MAX_VALUE) begin
            err_d   = 1'b1;
            value_d = '0;
            cnt_d   = '0;
          end else begin
            amount_d = value_q;
            av_d     = 1'b1;
            state_d  = ST_HOLD;
          end
        end else if (digit_ok) begin
          value_d = mac[VAL_W-1:0];
          cnt_d   = cnt_q + 2'd1;
          tmr_clr = 1'b1;
        end else begin
          // Rejected digits do not count as activity.
          tmr_inc = 1'b1;
          if (tmr_expire) begin
            to_d    = 1'b1;
            state_d = ST_IDLE;
            value_d = '0;
            cnt_d   = '0;
          end
        end
      end

      ST_HOLD: begin
        if (amount_ready) begin
          av_d    = 1'b0;
          state_d = ST_IDLE;
          value_d = '0;
          cnt_d   = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    act_d = (state_d == ST_ENTRY);
    unique case (state_d)
      ST_ENTRY: ev_d = value_d;
      ST_HOLD:  ev_d = amount_d;
      default:  ev_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      value_q  <= '0;
      cnt_q    <= '0;
      amount_q <= '0;
      av_q     <= 1'b0;
      err_q    <= 1'b0;
      to_q     <= 1'b0;
      act_q    <= 1'b0;
      ev_q     <= '0;
    end else begin
      state_q  <= state_d;
      value_q  <= value_d;
      cnt_q    <= cnt_d;
      amount_q <= amount_d;
      av_q     <= av_d;
      err_q    <= err_d;
      to_q     <= to_d;
      act_q    <= act_d;
      ev_q     <= ev_d;
    end
  end

  assign entry_active = act_q;
  assign entry_value  = ev_q;
  assign digit_cnt    = cnt_q;
  assign amount       = amount_q;
  assign amount_valid = av_q;
  assign err          = err_q;
  assign timeout      = to_q;

endmodule

// File: tb/tb_digit_entry_ctrl.sv
module tb_digit_entry_ctrl;

  localparam int VAL_W = 7;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       key_value = '0;
  logic             press_num = 1'b0;
  logic             start = 1'b0;
  logic             clear = 1'b0;
  logic             confirm = 1'b0;
  logic             amount_ready = 1'b0;
  logic             entry_active;
  logic [VAL_W-1:0] entry_value;
  logic [1:0]       digit_cnt;
  logic [VAL_W-1:0] amount;
  logic             amount_valid;
  logic             err;
  logic             timeout;

  int total = 0;
  int bad   = 0;

  digit_entry_ctrl #(
    .MAX_DIGITS(2), .MAX_VALUE(20), .VAL_W(VAL_W), .TIMEOUT_CYC(100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_value(key_value), .press_num(press_num),
    .start(start), .clear(clear), .confirm(confirm),
    .entry_active(entry_active), .entry_value(entry_value),
    .digit_cnt(digit_cnt), .amount(amount), .amount_valid(amount_valid),
    .amount_ready(amount_ready), .err(err), .timeout(timeout)
  );

  always #10 clk = ~clk;

  // Advance one edge and settle; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic s, input logic c, input logic f,
                        input logic p, input logic [3:0] k);
    start = s; clear = c; confirm = f; press_num = p; key_value = k;
    tick();
    start = 0; clear = 0; confirm = 0; press_num = 0; key_value = '0;
  endtask

  task automatic test_reset();
    #5;
    total++;
    if ({entry_active, entry_value, digit_cnt, amount, amount_valid, err, timeout} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got act=%0b val=%0d cnt=%0d amt=%0d av=%0b err=%0b to=%0b, want all 0",
               entry_active, entry_value, digit_cnt, amount, amount_valid, err, timeout);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_confirm();
    strobe(1, 0, 0, 0, 0);
    total++;
    if (entry_active !== 1'b1 || entry_value !== 7'd0) begin
      bad++; $display("FAIL start_entry: act=%0b val=%0d, want 1/0", entry_active, entry_value);
    end
    strobe(0, 0, 0, 1, 4'd1);
    total++;
    if (entry_value !== 7'd1 || digit_cnt !== 2'd1) begin
      bad++; $display("FAIL digit1: val=%0d cnt=%0d, want 1/1", entry_value, digit_cnt);
    end
    strobe(0, 0, 0, 1, 4'd5);
    total++;
    if (entry_value !== 7'd15 || digit_cnt !== 2'd2) begin
      bad++; $display("FAIL digit15: val=%0d cnt=%0d, want 15/2", entry_value, digit_cnt);
    end
    strobe(0, 0, 1, 0, 0);
    total++;
    if (amount_valid !== 1'b1 || amount !== 7'd15 || entry_active !== 1'b0 || entry_value !== 7'd15) begin
      bad++; $display("FAIL confirm15: av=%0b amt=%0d act=%0b val=%0d, want 1/15/0/15",
                      amount_valid, amount, entry_active, entry_value);
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 3) strobe(1, 0, 0, 1, 4'd2);   // key strobes ignored in HOLD
      else tick();
      total++;
      if (amount_valid !== 1'b1 || amount !== 7'd15 || entry_active !== 1'b0) begin
        bad++; $display("FAIL hold_stable[%0d]: av=%0b amt=%0d act=%0b, want 1/15/0",
                        i, amount_valid, amount, entry_active);
      end
    end
    amount_ready = 1'b1;
    tick();
    total++;
    if (amount_valid !== 1'b0 || entry_active !== 1'b0 || entry_value !== 7'd0) begin
      bad++; $display("FAIL handshake: av=%0b act=%0b val=%0d, want 0/0/0",
                      amount_valid, entry_active, entry_value);
    end
    // ready left high in IDLE must not disturb anything
    tick();
    amount_ready = 1'b0;
    total++;
    if (amount_valid !== 1'b0 || entry_active !== 1'b0) begin
      bad++; $display("FAIL ready_idle: av=%0b act=%0b, want 0/0", amount_valid, entry_active);
    end
  endtask

  task automatic test_err_confirm();
    strobe(1, 0, 0, 0, 0);
    strobe(0, 0, 0, 1, 4'd2);
    strobe(0, 0, 0, 1, 4'd5);
    strobe(0, 0, 1, 0, 0);
    total++;
    if (err !== 1'b1 || entry_value !== 7'd0 || entry_active !== 1'b1 ||
        digit_cnt !== 2'd0 || amount_valid !== 1'b0) begin
      bad++; $display("FAIL err25: err=%0b val=%0d act=%0b cnt=%0d av=%0b, want 1/0/1/0/0",
                      err, entry_value, entry_active, digit_cnt, amount_valid);
    end
    tick();
    total++;
    if (err !== 1'b0) begin
      bad++; $display("FAIL err_pulse_len: err=%0b, want 0", err);
    end
    strobe(0, 0, 0, 1, 4'd9);
    strobe(0, 0, 1, 0, 0);
    total++;
    if (amount_valid !== 1'b1 || amount !== 7'd9 || err !== 1'b0) begin
      bad++; $display("FAIL confirm9: av=%0b amt=%0d err=%0b, want 1/9/0", amount_valid, amount, err);
    end
    amount_ready = 1'b1;
    tick();
    amount_ready = 1'b0;
  endtask

  task automatic test_digit_limit();
    strobe(1, 0, 0, 0, 0);
    strobe(0, 0, 0, 1, 4'd1);
    strobe(0, 0, 0, 1, 4'd2);
    strobe(0, 0, 0, 1, 4'd3);
    total++;
    if (entry_value !== 7'd12 || digit_cnt !== 2'd2) begin
      bad++; $display("FAIL third_digit: val=%0d cnt=%0d, want 12/2", entry_value, digit_cnt);
    end
    strobe(0, 0, 0, 1, 4'hB);
    total++;
    if (entry_value !== 7'd12 || digit_cnt !== 2'd2) begin
      bad++; $display("FAIL key_B: val=%0d cnt=%0d, want 12/2", entry_value, digit_cnt);
    end
    strobe(0, 1, 0, 0, 0);
    strobe(0, 0, 0, 1, 4'hC);
    total++;
    if (entry_value !== 7'd0 || digit_cnt !== 2'd0 || entry_active !== 1'b1) begin
      bad++; $display("FAIL key_C_empty: val=%0d cnt=%0d act=%0b, want 0/0/1",
                      entry_value, digit_cnt, entry_active);
    end
  endtask

  task automatic test_timeout();
    strobe(1, 0, 0, 0, 0);
    strobe(0, 0, 0, 1, 4'd7);
    for (int i = 1; i <= 100; i++) begin
      tick();
      total++;
      if (i < 100 && (timeout !== 1'b0 || entry_active !== 1'b1)) begin
        bad++; $display("FAIL early_timeout[%0d]: to=%0b act=%0b, want 0/1", i, timeout, entry_active);
      end else if (i == 100 && (timeout !== 1'b1 || entry_active !== 1'b0 || entry_value !== 7'd0)) begin
        bad++; $display("FAIL timeout100: to=%0b act=%0b val=%0d, want 1/0/0",
                        timeout, entry_active, entry_value);
      end
    end
    tick();
    total++;
    if (timeout !== 1'b0 || digit_cnt !== 2'd0) begin
      bad++; $display("FAIL timeout_pulse_len: to=%0b cnt=%0d, want 0/0", timeout, digit_cnt);
    end
    // digit on the 99th idle cycle restarts the timer
    strobe(1, 0, 0, 0, 0);
    strobe(0, 0, 0, 1, 4'd7);
    for (int i = 1; i <= 98; i++) tick();
    strobe(0, 0, 0, 1, 4'd3);
    total++;
    if (timeout !== 1'b0 || entry_value !== 7'd73) begin
      bad++; $display("FAIL digit_at_99: to=%0b val=%0d, want 0/73", timeout, entry_value);
    end
    for (int i = 1; i <= 100; i++) begin
      tick();
      total++;
      if (i < 100 && timeout !== 1'b0) begin
        bad++; $display("FAIL restart_early[%0d]: to=%0b, want 0", i, timeout);
      end else if (i == 100 && (timeout !== 1'b1 || entry_active !== 1'b0)) begin
        bad++; $display("FAIL restart_timeout: to=%0b act=%0b, want 1/0", timeout, entry_active);
      end
    end
  endtask

  task automatic test_clear_confirm();
    strobe(1, 0, 0, 0, 0);
    strobe(0, 0, 0, 1, 4'd8);
    strobe(0, 1, 1, 0, 0);
    total++;
    if (entry_value !== 7'd0 || digit_cnt !== 2'd0 || amount_valid !== 1'b0 ||
        err !== 1'b0 || entry_active !== 1'b1) begin
      bad++; $display("FAIL clear_confirm: val=%0d cnt=%0d av=%0b err=%0b act=%0b, want 0/0/0/0/1",
                      entry_value, digit_cnt, amount_valid, err, entry_active);
    end
    strobe(0, 0, 0, 1, 4'd8);
    strobe(0, 0, 1, 0, 0);
    amount_ready = 1'b1;
    tick();
    amount_ready = 1'b0;
    strobe(0, 0, 0, 1, 4'd5);
    strobe(0, 0, 1, 0, 0);
    total++;
    if (entry_value !== 7'd0 || digit_cnt !== 2'd0 || entry_active !== 1'b0 || amount_valid !== 1'b0) begin
      bad++; $display("FAIL idle_ignore: val=%0d cnt=%0d act=%0b av=%0b, want 0/0/0/0",
                      entry_value, digit_cnt, entry_active, amount_valid);
    end
  endtask

  task automatic test_reset_hold();
    strobe(1, 0, 0, 0, 0);
    strobe(0, 0, 0, 1, 4'd1);
    strobe(0, 0, 0, 1, 4'd0);
`ifndef DIGIT_ENTRY_AUTOCONFIRM_EN
    strobe(0, 0, 1, 0, 0);
`else
    tick();
`endif
    total++;
    if (amount_valid !== 1'b1 || amount !== 7'd10) begin
      bad++; $display("FAIL hold10: av=%0b amt=%0d, want 1/10", amount_valid, amount);
    end
    #4 rst_n = 1'b0;
    #1;
    total++;
    if (amount_valid !== 1'b0 || amount !== 7'd0 || entry_value !== 7'd0) begin
      bad++; $display("FAIL async_reset: av=%0b amt=%0d val=%0d, want 0/0/0",
                      amount_valid, amount, entry_value);
    end
    tick();
    rst_n = 1'b1;
    tick();
    strobe(0, 0, 0, 1, 4'd3);
    total++;
    if (entry_active !== 1'b0 || entry_value !== 7'd0 || amount_valid !== 1'b0) begin
      bad++; $display("FAIL post_reset_idle: act=%0b val=%0d av=%0b, want 0/0/0",
                      entry_active, entry_value, amount_valid);
    end
  endtask

  initial begin
    test_reset();
`ifndef DIGIT_ENTRY_AUTOCONFIRM_EN
    test_basic_confirm();
    test_err_confirm();
    test_digit_limit();
    test_timeout();
    test_clear_confirm();
`endif
    test_reset_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
